// File: rtl/uart_tx_queue_pkg.sv
// Shared types and constants for the UART transmit queue.
package uart_pkg;

    // Byte width expected by UART_tx data_in.
    localparam int UART_DATA_W = 8;

    // Launch handshake states towards UART_tx.
    typedef enum logic [1:0] {
        TXQ_IDLE   = 2'd0,
        TXQ_LAUNCH = 2'd1,
        TXQ_WAIT   = 2'd2
    } txq_state_t;

    // Width of an occupancy counter able to hold 0..depth inclusive.
    function automatic int txq_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_tx_queue_if.sv
// Bundle of host-side push/status signals and the UART_tx handshake.
interface uart_tx_queue_if
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = UART_DATA_W
);
    localparam int CNT_W = txq_cnt_w(DEPTH);

    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              tx_wr_en;
    logic [DATA_W-1:0] tx_data;
    logic              tx_busy;

    // The queue itself.
    modport slave (
        input  wr_valid, wr_data, tx_busy,
        output full, empty, count, overflow, tx_wr_en, tx_data
    );

    // The environment: host pushing bytes plus the UART_tx busy flag.
    modport master (
        output wr_valid, wr_data, tx_busy,
        input  full, empty, count, overflow, tx_wr_en, tx_data
    );

endinterface

// File: rtl/uart_tx_queue_fifo.sv
// Synchronous byte FIFO: storage, pointers, occupancy count and sticky overflow.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = UART_DATA_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [DATA_W-1:0]          push_data_i,
    input  logic                       pop_i,
    output logic [DATA_W-1:0]          pop_data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       overflow_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              push_ok;
    logic              pop_ok;

    // Flags come only from the registered count; pointers are free to wrap.
    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign overflow_o = overflow_q;
    assign pop_data_o = mem_q[rptr_q];

    // A push while full is refused even if a pop frees a slot this cycle.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Next-state for pointers, occupancy and the sticky overflow flag.
    always_comb begin
        wptr_d     = wptr_q + PTR_W'(push_ok);
        rptr_d     = rptr_q + PTR_W'(pop_ok);
        count_d    = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        overflow_d = overflow_q || (push_i && full_o);
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Byte storage; contents are meaningless until counted, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wptr_q] <= push_data_i;
        end
    end

    // Occupancy can never leave the 0..DEPTH range.
    always @(posedge clk) begin
        if (!rst) begin
            assert (count_q <= CNT_W'(DEPTH));
        end
    end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue in front of UART_tx: buffers host bursts and launches one byte
// at a time using the wr_en / tx_busy handshake.
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = UART_DATA_W
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_queue_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    txq_state_t        state_q, state_d;
    logic              tx_wr_en_q, tx_wr_en_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              pop;
    logic [DATA_W-1:0] head_data;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_overflow;
    logic [CNT_W-1:0]  fifo_count;

    sync_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (bus.wr_valid),
        .push_data_i (bus.wr_data),
        .pop_i       (pop),
        .pop_data_o  (head_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count),
        .overflow_o  (fifo_overflow)
    );

    // Handshake FSM: pop into tx_data, hold wr_en until busy rises, then
    // wait for the frame to finish before the next pop.
    always_comb begin
        state_d    = state_q;
        tx_wr_en_d = tx_wr_en_q;
        tx_data_d  = tx_data_q;
        pop        = 1'b0;
        case (state_q)
            TXQ_IDLE: begin
                // A frame started elsewhere keeps us idle until it ends.
                if (!fifo_empty && !bus.tx_busy) begin
                    pop        = 1'b1;
                    tx_data_d  = head_data;
                    tx_wr_en_d = 1'b1;
                    state_d    = TXQ_LAUNCH;
                end
            end
            TXQ_LAUNCH: begin
                if (bus.tx_busy) begin
                    tx_wr_en_d = 1'b0;
                    state_d    = TXQ_WAIT;
                end
            end
            TXQ_WAIT: begin
                if (!bus.tx_busy) begin
                    state_d = TXQ_IDLE;
                end
            end
            default: begin
                tx_wr_en_d = 1'b0;
                state_d    = TXQ_IDLE;
            end
        endcase
    end

    // FSM and launch registers; reset drops wr_en but cannot abort a frame
    // UART_tx has already accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= TXQ_IDLE;
            tx_wr_en_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            tx_wr_en_q <= tx_wr_en_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign bus.full     = fifo_full;
    assign bus.empty    = fifo_empty;
    assign bus.count    = fifo_count;
    assign bus.overflow = fifo_overflow;
    assign bus.tx_wr_en = tx_wr_en_q;
    assign bus.tx_data  = tx_data_q;

endmodule
